fdiv_seq: RTL
=============

FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rstn  in  1  reset, synchronous, active-low.
REQ-003 x1  in  32  dividend, IEEE-754 binary32.
REQ-004 x2  in  32  divisor, IEEE-754 binary32.
REQ-005 in_valid  in  1  x1/x2 valid this cycle.
REQ-006 in_ready  out  1  unit idle and accepts operands.
REQ-007 y  out  32  quotient x1/x2, binary32.
REQ-008 out_valid  out  1  y valid.
REQ-009 out_ready  in  1  consumer takes y this cycle.

Function
REQ-010 Accept occurs on a cycle with in_valid && in_ready; x1/x2 SHALL be registered then and ignored afterwards.
REQ-011 One operation outstanding at most; in_ready SHALL be high only in IDLE.
REQ-012 States: IDLE -> PREP (1 cycle) -> DIV (26 cycles) -> ROUND (1 cycle) -> DONE; DONE -> IDLE on out_ready.
REQ-013 out_valid SHALL rise exactly 29 cycles after the accept edge, special cases included (fixed latency).
REQ-014 In DONE, y and out_valid SHALL hold stable until out_ready is sampled high; the next cycle is IDLE with out_valid=0.
REQ-015 Sign = x1[31] ^ x2[31] for every result, NaN excepted.
REQ-016 Exponent field 0 SHALL mean zero; denormal inputs flush to signed zero, and no denormal is ever output.
REQ-017 PREP: ma={1,m1}, mb={1,m2}; if ma<mb then ma<<=1 and adj=1; exp = e1 - e2 + 127 - adj, signed 10-bit.
REQ-018 DIV: restoring division, 1 quotient bit per cycle, 26 bits (24 mantissa + guard + round); sticky = (final remainder != 0).
REQ-019 ROUND: round-to-nearest-even on guard/round/sticky; a mantissa carry-out SHALL increment exp.
REQ-020 After rounding, exp>=255 SHALL give signed infinity and exp<=0 SHALL give signed zero.
REQ-021 Specials, priority order: any NaN input or 0/0 or inf/inf -> 32'h7FC00000; x1 inf or x2 zero -> signed inf; x1 zero or x2 inf -> signed zero.
REQ-022 For normal results y SHALL be bit-exact to IEEE RNE division.

Reset
REQ-023 rstn low at any edge SHALL force IDLE, out_valid=0, y=0 and in_ready=1 on the following cycle, aborting any operation in flight.
REQ-024 An operation aborted by reset SHALL produce no output, and the first accept after reset SHALL behave normally.

Structure
REQ-025 Package fpu_pkg SHALL hold: the state enum, BIAS=127, DIV_ITERS=26, QNAN=32'h7FC00000, PINF=32'h7F800000.
REQ-026 One sub-module fdiv_mant_iter SHALL hold the restoring-division datapath (remainder, quotient shift register, iteration counter).
REQ-027 Special-case classification and rounding SHALL stay in fdiv_seq.

Verification
REQ-028 3F800000/40000000 -> y=3F000000; out_valid exactly 29 cycles after accept.
REQ-029 3F800000/40400000 -> 3EAAAAAB (RNE up); 40C00000/C0000000 -> C0400000.
REQ-030 3F800000/00000000 -> 7F800000; 00000000/00000000 -> 7FC00000; 7F800000/7F800000 -> 7FC00000.
REQ-031 7F000000/00800000 -> 7F800000 (overflow); 00800000/7F000000 -> 00000000 (underflow).
REQ-032 Handshake: out_ready held low 10 cycles -> y stable and in_ready=0 throughout; rstn low in DIV cycle 12 -> next cycle out_valid=0 and in_ready=1.
REQ-033 Random: 1000 normal operand pairs (fixed seed) checked against $shortreal division, zero mismatches.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential binary32 divider.
package fpu_pkg;

  localparam int unsigned BIAS      = 127;
  localparam int unsigned DIV_ITERS = 26;
  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam logic [31:0] PINF      = 32'h7F800000;

  localparam int unsigned MANT_W = 24;          // mantissa with hidden bit
  localparam int unsigned Q_W    = DIV_ITERS;   // quotient bits incl. guard/round
  localparam int unsigned REM_W  = MANT_W + 2;  // remainder never reaches 2*divisor
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned EXP_W  = 10;          // signed working exponent

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_ROUND,
    S_DONE
  } state_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fclass_t;

  // Exponent field 0 is zero: denormals are flushed.
  function automatic fclass_t classify(input logic [31:0] f);
    fclass_t c;
    c.nan  = (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    c.inf  = (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    c.zero = (f[30:23] == 8'h00);
    return c;
  endfunction

endpackage

// File: rtl/fdiv_mant_iter.sv
// Restoring mantissa divider, one quotient bit per cycle.
//   load     : capture dividend/divisor and start DIV_ITERS iterations
//   dividend : normalised dividend, already pre-shifted so quotient is in [1,2)
//   divisor  : normalised divisor {1,m}
//   quot     : quotient shift register (MSB is the integer bit)
//   sticky_c : remainder non-zero
//   last_c   : the current cycle performs the final iteration
module fdiv_mant_iter
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [MANT_W:0]   dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic [Q_W-1:0]    quot,
  output logic              sticky_c,
  output logic              last_c
);

  logic [REM_W-1:0]  rem_q;
  logic [MANT_W-1:0] div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ge;
  logic [REM_W-1:0]  diff;

  // Trial subtraction for the current bit.
  always_comb begin
    ge   = rem_q >= REM_W'(div_q);
    diff = ge ? (rem_q - REM_W'(div_q)) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      quot  <= '0;
    end else if (load) begin
      rem_q <= REM_W'(dividend);
      div_q <= divisor;
      cnt_q <= CNT_W'(DIV_ITERS);
      quot  <= '0;
    end else if (cnt_q != '0) begin
      quot  <= {quot[Q_W-2:0], ge};
      rem_q <= {diff[REM_W-2:0], 1'b0};
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign sticky_c = (rem_q != '0);
  assign last_c   = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 binary32 divider, round-to-nearest-even, fixed latency.
//   clk, rstn : clock, synchronous active-low reset
//   x1, x2    : dividend / divisor, captured on in_valid && in_ready
//   in_ready  : unit idle
//   y         : quotient, held while out_valid is high
//   out_valid : result available; out_ready consumes it
module fdiv_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  state_e state_q, state_d;

  logic [31:0]             a_q, b_q;
  logic                    sign_q;
  logic signed [EXP_W-1:0] exp_q;
  logic                    spec_q;
  logic [31:0]             spec_val_q;

  logic        load_ops, capture, iter_load;
  logic [31:0] y_d;
  logic        out_valid_d, in_ready_d;

  logic [Q_W-1:0] quot;
  logic           sticky_c, last_c;

  // PREP: classification, mantissa alignment and exponent difference.
  fclass_t                 ca, cb;
  logic [MANT_W-1:0]       ma0, mb;
  logic                    adj;
  logic [MANT_W:0]         ma;
  logic signed [EXP_W-1:0] exp_prep;
  logic                    sign_prep, spec_prep;
  logic [31:0]             spec_val_prep;

  always_comb begin
    ca        = classify(a_q);
    cb        = classify(b_q);
    ma0       = {1'b1, a_q[22:0]};
    mb        = {1'b1, b_q[22:0]};
    adj       = ma0 < mb;
    ma        = adj ? {ma0, 1'b0} : {1'b0, ma0};
    exp_prep  = EXP_W'(a_q[30:23]) - EXP_W'(b_q[30:23]) + EXP_W'(BIAS) - EXP_W'(adj);
    sign_prep = a_q[31] ^ b_q[31];
    spec_prep     = 1'b1;
    spec_val_prep = QNAN;
    if (ca.nan || cb.nan || (ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
      spec_val_prep = QNAN;
    end else if (ca.inf || cb.zero) begin
      spec_val_prep = {sign_prep, PINF[30:0]};
    end else if (ca.zero || cb.inf) begin
      spec_val_prep = {sign_prep, 31'd0};
    end else begin
      spec_prep = 1'b0;
    end
  end

  fdiv_mant_iter u_iter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (iter_load),
    .dividend (ma),
    .divisor  (mb),
    .quot     (quot),
    .sticky_c (sticky_c),
    .last_c   (last_c)
  );

  // ROUND: RNE on guard/round/sticky, then range checks.
  logic                    rup;
  logic [MANT_W:0]         mant_r;
  logic signed [EXP_W-1:0] exp_r;
  logic [31:0]             y_res;

  always_comb begin
    rup    = quot[1] & (quot[0] | sticky_c | quot[2]);
    mant_r = {1'b0, quot[Q_W-1:2]} + (MANT_W+1)'(rup);
    exp_r  = exp_q + EXP_W'(mant_r[MANT_W]);
    if (spec_q) begin
      y_res = spec_val_q;
    end else if (exp_r >= 10'sd255) begin
      y_res = {sign_q, PINF[30:0]};
    end else if (exp_r <= 10'sd0) begin
      y_res = {sign_q, 31'd0};
    end else begin
      y_res = {sign_q, exp_r[7:0], mant_r[MANT_W-2:0]};
    end
  end

  // Next state and next register values.
  always_comb begin
    state_d     = state_q;
    load_ops    = 1'b0;
    capture     = 1'b0;
    iter_load   = 1'b0;
    y_d         = y;
    out_valid_d = out_valid;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load_ops = 1'b1;
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        capture   = 1'b1;
        iter_load = 1'b1;
        state_d   = S_DIV;
      end
      S_DIV: begin
        if (last_c) state_d = S_ROUND;
      end
      S_ROUND: begin
        y_d     = y_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        // out_valid trails entry into DONE by one cycle: 29-cycle latency.
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Outputs and operation context.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y          <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
    end else begin
      y         <= y_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      if (load_ops) begin
        a_q <= x1;
        b_q <= x2;
      end
      if (capture) begin
        sign_q     <= sign_prep;
        exp_q      <= exp_prep;
        spec_q     <= spec_prep;
        spec_val_q <= spec_val_prep;
      end
    end
  end

endmodule
